// File: rtl/param_memory.sv
// Parametrised memory: registered-read instruction port, byte-enabled read/write data port,
// hardware zero-clear after reset. Define PARAM_MEMORY_BYPASS_EN for write-first forwarding.
module param_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   iAddr,
  output logic [DATA_WIDTH-1:0]   iDataOut,
  input  logic [ADDR_WIDTH-1:0]   dAddr,
  input  logic                    dWrEn,
  input  logic [DATA_WIDTH/8-1:0] dByteEn,
  input  logic [DATA_WIDTH-1:0]   dDataIn,
  output logic [DATA_WIDTH-1:0]   dDataOut,
  output logic                    busy
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned PW     = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state, state_nx;
  logic [PW-1:0]           ptr, ptr_nx;
  logic                    busy_nx;
  logic [DATA_WIDTH-1:0]   idata_nx, ddata_nx;
  logic                    i_in, d_in, wr_hit, clr_we;
  logic [DATA_WIDTH-1:0]   i_word, d_word, merged;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign i_in = {1'b0, iAddr} < DEPTH_P;
  assign d_in = {1'b0, dAddr} < DEPTH_P;

  // Range-guarded reads and the byte-merged word a write would store.
  always_comb begin
    i_word = i_in ? mem[iAddr] : '0;
    d_word = d_in ? mem[dAddr] : '0;
    merged = d_word;
    for (int k = 0; k < NBYTES; k++) begin
      if (dByteEn[k]) merged[8*k +: 8] = dDataIn[8*k +: 8];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      ptr      <= '0;
      busy     <= 1'b1;
      iDataOut <= '0;
      dDataOut <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      busy     <= busy_nx;
      iDataOut <= idata_nx;
      dDataOut <= ddata_nx;
    end
  end

  // Next-state, clear sequencing and read-data selection.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    busy_nx  = busy;
    idata_nx = iDataOut;
    ddata_nx = dDataOut;
    wr_hit   = 1'b0;
    clr_we   = 1'b0;
    case (state)
      CLEAR: begin
        clr_we   = 1'b1;
        ptr_nx   = ptr + PW'(1);
        busy_nx  = 1'b1;
        idata_nx = '0;
        ddata_nx = '0;
        if (ptr == LAST) begin
          state_nx = READY;
          busy_nx  = 1'b0;
        end
      end
      READY: begin
        wr_hit   = dWrEn && d_in;
        busy_nx  = 1'b0;
        idata_nx = i_word;
        ddata_nx = d_word;
`ifdef PARAM_MEMORY_BYPASS_EN
        if (wr_hit) begin
          ddata_nx = merged;
          if (iAddr == dAddr) idata_nx = merged;
        end
`endif
      end
    endcase
  end

  // Storage: zero-fill during clear, byte-merged writes when ready; nothing on a reset edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) mem[ptr[ADDR_WIDTH-1:0]] <= '0;
      else if (wr_hit) mem[dAddr] <= merged;
    end
  end

endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: a full-depth (16) and a partial-depth (12) instance share stimulus
// and are checked every cycle against a word-array reference model.
module tb_param_memory;

  logic        clk;
  logic        reset;
  logic [3:0]  iAddr, dAddr;
  logic        dWrEn;
  logic [3:0]  dByteEn;
  logic [31:0] dDataIn;
  logic [31:0] i16, d16, i12, d12;
  logic        b16, b12;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] mm [2][16];
  int          dep [2] = '{16, 12};
  int          clr [2];
  logic [31:0] ei [2], ed [2];
  logic        eb [2];

  param_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16)) u16 (
    .clk(clk), .reset(reset), .iAddr(iAddr), .iDataOut(i16), .dAddr(dAddr), .dWrEn(dWrEn),
    .dByteEn(dByteEn), .dDataIn(dDataIn), .dDataOut(d16), .busy(b16));

  param_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12)) u12 (
    .clk(clk), .reset(reset), .iAddr(iAddr), .iDataOut(i12), .dAddr(dAddr), .dWrEn(dWrEn),
    .dByteEn(dByteEn), .dDataIn(dDataIn), .dDataOut(d12), .busy(b12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: a memory is busy for dep[] non-reset edges after reset, then reads/writes words.
  task automatic model_step();
    logic [31:0] old, mrg;
    bit          din, iin, hit;
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        clr[n] = dep[n];
        for (int j = 0; j < 16; j++) mm[n][j] = 32'h0;
        ei[n] = 32'h0; ed[n] = 32'h0; eb[n] = 1'b1;
      end else if (clr[n] != 0) begin
        clr[n]--;
        ei[n] = 32'h0; ed[n] = 32'h0; eb[n] = (clr[n] != 0);
      end else begin
        din = int'(dAddr) < dep[n];
        iin = int'(iAddr) < dep[n];
        old = din ? mm[n][dAddr] : 32'h0;
        mrg = old;
        for (int k = 0; k < 4; k++) if (dByteEn[k]) mrg[8*k +: 8] = dDataIn[8*k +: 8];
        hit   = dWrEn && din;
        ed[n] = old;
        ei[n] = iin ? mm[n][iAddr] : 32'h0;
`ifdef PARAM_MEMORY_BYPASS_EN
        if (hit) begin
          ed[n] = mrg;
          if (iAddr == dAddr) ei[n] = mrg;
        end
`endif
        if (hit) mm[n][dAddr] = mrg;
        eb[n] = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic [3:0] ia, input logic [3:0] da,
                       input logic we, input logic [3:0] be, input logic [31:0] di);
    reset = rst; iAddr = ia; dAddr = da; dWrEn = we; dByteEn = be; dDataIn = di;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("i16", i16, ei[0]);
    check("d16", d16, ed[0]);
    check("b16", 32'(b16), 32'(eb[0]));
    check("i12", i12, ei[1]);
    check("d12", d12, ed[1]);
    check("b12", 32'(b12), 32'(eb[1]));
  endtask

  task automatic rd(input logic [3:0] a);
    cycle(1'b0, a, a, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] v);
    cycle(1'b0, 4'h0, a, 1'b1, be, v);
  endtask

  // Run released cycles until the depth-16 instance drops busy; returns the edge count.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      cycle(1'b0, 4'h0, 4'h2, 1'b1, 4'hF, 32'hBAD0BAD0);
      n++;
    end while (b16 && n < 100);
  endtask

  initial begin
    int n;
    logic [31:0] coll;
    reset = 1'b1; iAddr = '0; dAddr = '0; dWrEn = 1'b0; dByteEn = '0; dDataIn = '0;
    @(negedge clk);

    for (int c = 0; c < 3; c++) cycle(1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    wait_ready(n);
    check("clear_edges", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      check("clear_rd", d16, 32'h0);
    end

    wr(4'd5, 4'hF, 32'hDEADBEEF);
    wr(4'd5, 4'b0101, 32'h11223344);
    rd(4'd5);
    check("be_d", d16, 32'hDE22BE44);
    check("be_i", i16, 32'hDE22BE44);

    wr(4'd3, 4'hF, 32'hAAAAAAAA);
    cycle(1'b0, 4'd3, 4'd3, 1'b1, 4'hF, 32'h55555555);
`ifdef PARAM_MEMORY_BYPASS_EN
    coll = 32'h55555555;
`else
    coll = 32'hAAAAAAAA;
`endif
    check("coll_d", d16, coll);
    check("coll_i", i16, coll);
    rd(4'd3);
    check("coll_next_d", d16, 32'h55555555);
    check("coll_next_i", i16, 32'h55555555);

    wr(4'd13, 4'hF, 32'h12345678);
    rd(4'd13);
    check("oor_13", d12, 32'h0);
    rd(4'd1);
    check("oor_alias", d12, 32'h0);
    wr(4'd11, 4'hF, 32'h0BADF00D);
    rd(4'd11);
    check("edge_11", d12, 32'h0BADF00D);

    wr(4'd0, 4'hF, 32'hCAFEF00D);
    cycle(1'b1, 4'd0, 4'd0, 1'b1, 4'hF, 32'h77777777);
    check("rst_d", d16, 32'h0);
    check("rst_busy", 32'(b16), 32'd1);
    for (int c = 0; c < 9; c++) cycle(1'b0, 4'h0, 4'd2, 1'b1, 4'hF, 32'h22222222);
    cycle(1'b1, 4'h0, 4'd2, 1'b1, 4'hF, 32'h33333333);
    check("midclr_busy", 32'(b16), 32'd1);
    wait_ready(n);
    check("midclr_edges", 32'(n), 32'd16);
    rd(4'd2);
    check("midclr_a2", d16, 32'h0);
    rd(4'd0);
    check("rst_a0", d16, 32'h0);

    for (int c = 0; c < 600; c++) begin
      cycle(($urandom_range(99) == 0), 4'($urandom_range(15)), 4'($urandom_range(15)),
            1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
- Parametrised synchronous-write memory with two ports:
  - instruction read port (port I);
  - data read/write port with byte enables (port D).
- Successor to the fixed 32x1024 asynchronous-read memory. Adds configurable width and depth, registered reads, and a hardware clear sequence after reset.
- Sits between the CPU fetch/load-store units and storage.
- Guarantees defined contents (all zero) after reset, instead of undefined contents.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word-address width of both ports.
- DEPTH, 1024, number of implemented words; 1 <= DEPTH <= 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- iAddr  input  ADDR_WIDTH  port I word address.
- iDataOut  output  DATA_WIDTH  port I registered read data.
- dAddr  input  ADDR_WIDTH  port D word address.
- dWrEn  input  1  port D write strobe.
- dByteEn  input  DATA_WIDTH/8  per-byte write enable; bit k covers bits [8k+7:8k].
- dDataIn  input  DATA_WIDTH  port D write data.
- dDataOut  output  DATA_WIDTH  port D registered read data.
- busy  output  1  high while the clear sequence runs; the memory is unusable while high.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset, at any edge with reset=1, including mid-clear or mid-operation:
  - state goes to CLEAR and the clear pointer goes to 0;
  - iDataOut=0, dDataOut=0, busy=1;
  - a pending write on that edge is discarded.
- State machine, two states:
  - CLEAR: on each edge with reset=0, mem[ptr]<=0 and ptr<=ptr+1. On the edge where ptr==DEPTH-1, the last word is cleared and the state moves to READY with busy<=0.
  - Net effect: busy falls exactly DEPTH edges after the first edge with reset=0.
  - READY: normal operation; remains READY until reset.
- While in CLEAR:
  - dWrEn is ignored;
  - iDataOut and dDataOut are held at 0.
- Reads in READY:
  - latency 1; the output register loads mem[addr] at the edge and holds until the next edge;
  - both ports may read any addresses simultaneously, including the same address.
- Writes in READY:
  - when dWrEn=1, for each k with dByteEn[k]=1, mem[dAddr] byte k <= dDataIn byte k;
  - bytes with dByteEn[k]=0 are unchanged;
  - dWrEn=1 with dByteEn all zero is a no-op.
- Read during write, same edge, same address, without the optional feature: read-first. dDataOut, and iDataOut if iAddr==dAddr, return the pre-write word.
- Out of range (addr >= DEPTH, possible only when DEPTH < 2^ADDR_WIDTH):
  - reads return 0;
  - writes are ignored;
  - no wrap-around or aliasing.
- Address arithmetic: ptr is ADDR_WIDTH+1 bits wide so that DEPTH=2^ADDR_WIDTH terminates without overflow.
- No X ever appears on the outputs after the first reset edge.

Optional Feature:
- Macro: PARAM_MEMORY_BYPASS_EN.
- Defined: write-to-read forwarding.
  - When dWrEn=1 in READY and a port's read address equals dAddr in range, that port's output loads the merged word: new bytes where dByteEn=1, old bytes elsewhere (write-first).
  - Applies independently to port I and port D.
- Undefined: read-first, as in Behaviour.
- Storage contents are identical in both builds; only same-cycle read data differs.

Test Plan:
- Clear sequence. Parameters DATA_WIDTH=32, ADDR_WIDTH=4, DEPTH=16; hold reset 3 cycles, then release.
  - iDataOut=dDataOut=0 and busy=1 throughout.
  - busy falls after exactly 16 edges.
  - Reading all 16 addresses then returns 32'h0.
- Byte-enable write. Write 32'hDEADBEEF to address 5 with dByteEn=4'hF, then write 32'h11223344 with dByteEn=4'b0101.
  - Read of address 5 on port D returns 32'hDE22BE44 one cycle after the read address is applied.
  - Port I at iAddr=5 returns the same value.
- Collision. Address 3 holds 32'hAAAAAAAA; write 32'h55555555 to address 3 with dByteEn=4'hF while iAddr=3.
  - Without the macro: dDataOut=iDataOut=32'hAAAAAAAA at that edge.
  - With PARAM_MEMORY_BYPASS_EN: both equal 32'h55555555.
  - The next read returns 32'h55555555 in both builds.
- Reset mid-clear. DEPTH=16; assert reset for 1 cycle at clear pointer 9.
  - busy stays high.
  - busy falls 16 edges after the re-release, not 7.
  - A write attempted during clear to address 2 is lost; address 2 reads 0.
- Out of range. ADDR_WIDTH=4, DEPTH=12; write 32'h12345678 to address 13.
  - Reading address 13 returns 0.
  - Reading address 1 returns 0, so there is no alias.
  - Address 11 write and read work normally.
- Reset in READY. Fill address 0 with 32'hCAFEF00D, then assert reset.
  - Outputs are 0 at that edge and busy=1.
  - After the clear completes, address 0 reads 0.
